cache_fill_responder: RTL and testbench



---
 rtl/cache_fill_responder_if.sv | 45 ++++
 rtl/cache_fill_responder.sv | 157 +++++++++++++++
 tb/tb_cache_fill_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_responder_if.sv
// cache_fill_responder_if
// Bundles the instruction-port and data-port request/response signals
// between the caches and the backing-memory responder.
//   master : cache side   (drives requests, sinks responses and status)
//   slave  : responder    (accepts requests, drives responses and status)
// Signals:
//   ireq_valid/ireq_ready/ireq_addr[35:0]      instruction fill request
//   iresp_valid/iresp_data[127:0]              instruction fill response
//   dreq_valid/dreq_ready/dreq_addr[35:0]      data request
//   dreq_we/dreq_wdata[127:0]                  data write enable and line
//   dresp_valid/dresp_data[127:0]              data read line or write echo
//   busy                                       responder not idle
//   err                                        sticky range error
interface cache_fill_responder_if;
    logic         ireq_valid;
    logic         ireq_ready;
    logic [35:0]  ireq_addr;
    logic         iresp_valid;
    logic [127:0] iresp_data;
    logic         dreq_valid;
    logic         dreq_ready;
    logic [35:0]  dreq_addr;
    logic         dreq_we;
    logic [127:0] dreq_wdata;
    logic         dresp_valid;
    logic [127:0] dresp_data;
    logic         busy;
    logic         err;

    modport master (
        output ireq_valid, ireq_addr,
        output dreq_valid, dreq_addr, dreq_we, dreq_wdata,
        input  ireq_ready, iresp_valid, iresp_data,
        input  dreq_ready, dresp_valid, dresp_data,
        input  busy, err
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        input  dreq_valid, dreq_addr, dreq_we, dreq_wdata,
        output ireq_ready, iresp_valid, iresp_data,
        output dreq_ready, dresp_valid, dresp_data,
        output busy, err
    );
endinterface

// File: rtl/cache_fill_responder.sv
// cache_fill_responder
// Backing memory for instruction/data cache line traffic. Holds one request
// at a time, arbitrates round-robin between the instruction and data ports,
// and answers after a fixed LATENCY from a 128-bit line array.
// Parameters:
//   LATENCY   access latency in cycles (1..255)
//   LINE_BITS log2 of the number of lines
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    cache_fill_responder_if.slave (requests, responses, busy, err)
// Optional feature:
//   FILL_RANGE_CHECK_EN  when defined, requests with address bits above the
//   array range are flagged: they answer with 0, writes are dropped and the
//   sticky err output sets. When undefined, upper bits alias and err is 0.
module cache_fill_responder #(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 10
) (
    input logic                    clk,
    input logic                    rst_n,
    cache_fill_responder_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int         LINES   = 1 << LINE_BITS;
    localparam int         IDX_HI  = LINE_BITS + 3;

    logic [1:0]           r_state;
    logic                 r_prio_d;    // 1: data port wins a tie
    logic                 r_port_d;    // granted port of the open request
    logic                 r_we;
    logic                 r_bad;       // open request is out of range
    logic [7:0]           r_cnt;
    logic [LINE_BITS-1:0] r_idx;
    logic [127:0]         r_wdata;
    logic [127:0]         r_iresp_data;
    logic [127:0]         r_dresp_data;
    logic [127:0]         r_mem [LINES];

    logic                 w_idle;
    logic                 w_sel_d;
    logic                 w_accept;
    logic                 w_commit;
    logic                 w_req_bad;
    logic [35:0]          w_addr;
    logic                 w_unused_addr;

    assign w_idle = (r_state == ST_IDLE);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_d = r_prio_d;
        if (bus.dreq_valid && !bus.ireq_valid) begin
            w_sel_d = 1'b1;
        end else if (bus.ireq_valid && !bus.dreq_valid) begin
            w_sel_d = 1'b0;
        end
    end

    // Exactly one ready while idle; none while reset is held.
    assign bus.dreq_ready = rst_n && w_idle && w_sel_d;
    assign bus.ireq_ready = rst_n && w_idle && !w_sel_d;

    assign w_accept = w_idle && (w_sel_d ? bus.dreq_valid : bus.ireq_valid);
    assign w_addr   = w_sel_d ? bus.dreq_addr : bus.ireq_addr;
    assign w_commit = (r_state == ST_WAIT) && (r_cnt == 8'd0);

`ifdef FILL_RANGE_CHECK_EN
    assign w_req_bad = |w_addr[35:LINE_BITS+4];
`else
    assign w_req_bad = 1'b0;
`endif

    // Byte offset is ignored; upper bits are only looked at by the range check.
    assign w_unused_addr = ^{w_addr[3:0], w_addr[35:LINE_BITS+4]};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_prio_d     <= 1'b1;
            r_port_d     <= 1'b0;
            r_we         <= 1'b0;
            r_bad        <= 1'b0;
            r_cnt        <= 8'd0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_iresp_data <= '0;
            r_dresp_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_WAIT;
                        r_port_d <= w_sel_d;
                        r_prio_d <= !w_sel_d;
                        r_idx    <= w_addr[IDX_HI:4];
                        r_we     <= w_sel_d && bus.dreq_we;
                        r_wdata  <= bus.dreq_wdata;
                        r_bad    <= w_req_bad;
                        r_cnt    <= 8'(LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        // Access happens on this edge; the response register
                        // is ready for the RESP cycle that follows.
                        r_state <= ST_RESP;
                        if (r_port_d) begin
                            r_dresp_data <= r_bad ? '0 : (r_we ? r_wdata : r_mem[r_idx]);
                        end else begin
                            r_iresp_data <= r_bad ? '0 : r_mem[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the line array is deliberately not reset; it models RAM whose
    // contents survive a reset and must not carry a reset network.
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !r_bad) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef FILL_RANGE_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_commit && r_bad) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy        = !w_idle;
    assign bus.iresp_valid = (r_state == ST_RESP) && !r_port_d;
    assign bus.dresp_valid = (r_state == ST_RESP) && r_port_d;
    assign bus.iresp_data  = r_iresp_data;
    assign bus.dresp_data  = r_dresp_data;
endmodule

// File: tb/tb_cache_fill_responder.sv
// tb_cache_fill_responder
// Self-checking bench for cache_fill_responder. A transaction-level model
// (request age, round-robin pointer, line memory as an associative array)
// predicts readys, busy, response pulses, data and err every cycle; directed
// sequences pin literal timing and data. A second instance runs LATENCY=1.
// Honours FILL_RANGE_CHECK_EN the same way the design does.
module tb_cache_fill_responder;
    localparam int LAT = 4;
    localparam int LB  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    cache_fill_responder_if bus ();
    cache_fill_responder_if bus1 ();

    cache_fill_responder #(.LATENCY(LAT), .LINE_BITS(LB)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cache_fill_responder #(.LATENCY(1), .LINE_BITS(LB)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [35:0] a);
`ifdef FILL_RANGE_CHECK_EN
        return |a[35:LB+4];
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    bit           m_out;          // a request is outstanding
    int           m_age;          // cycles since its accept cycle
    bit           m_port_d, m_we, m_bad, m_prio_d, m_err;
    int           m_idx;
    logic [127:0] m_wdata;
    logic [127:0] m_mem [int];
    logic [127:0] m_last_i, m_last_d;
    bit           m_known_i, m_known_d;
    bit           m_acc_i, m_acc_d;

    always @(negedge clk) begin
        bit           exp_busy, exp_ri, exp_rd, exp_vi, exp_vd, sel_d, known;
        logic [127:0] data;
        exp_busy = 0; exp_ri = 0; exp_rd = 0; exp_vi = 0; exp_vd = 0;
        sel_d = 0; known = 1; data = '0;
        m_acc_i = 0;
        m_acc_d = 0;
        if (!rst_n) begin
            // A write whose commit edge already passed stays in memory.
            if (m_out && m_age + 1 >= LAT + 1 && m_we && !m_bad) m_mem[m_idx] = m_wdata;
            m_out = 0; m_prio_d = 1; m_err = 0;
            m_last_i = '0; m_last_d = '0; m_known_i = 1; m_known_d = 1;
        end else begin
            if (m_out) begin
                m_age++;
                if (m_age == LAT + 1) begin
                    if (m_bad) begin
                        data = '0;
                        m_err = 1;
                    end else if (m_we) begin
                        m_mem[m_idx] = m_wdata;
                        data = m_wdata;
                    end else if (m_mem.exists(m_idx)) begin
                        data = m_mem[m_idx];
                    end else begin
                        known = 0;
                    end
                    if (m_port_d) begin
                        exp_vd = 1; m_last_d = data; m_known_d = known;
                    end else begin
                        exp_vi = 1; m_last_i = data; m_known_i = known;
                    end
                end else if (m_age == LAT + 2) begin
                    m_out = 0;
                end
            end
            exp_busy = m_out;
            if (!m_out) begin
                if (bus.dreq_valid && !bus.ireq_valid)      sel_d = 1;
                else if (bus.ireq_valid && !bus.dreq_valid) sel_d = 0;
                else                                        sel_d = m_prio_d;
                exp_rd = sel_d;
                exp_ri = !sel_d;
                if (sel_d ? bus.dreq_valid : bus.ireq_valid) begin
                    m_out    = 1;
                    m_age    = 0;
                    m_port_d = sel_d;
                    m_prio_d = !sel_d;
                    m_we     = sel_d && bus.dreq_we;
                    m_wdata  = bus.dreq_wdata;
                    m_idx    = int'(sel_d ? bus.dreq_addr[LB+3:4] : bus.ireq_addr[LB+3:4]);
                    m_bad    = out_of_range(sel_d ? bus.dreq_addr : bus.ireq_addr);
                    if (sel_d) m_acc_d = 1; else m_acc_i = 1;
                end
            end
        end
        if (rst_n && !exp_busy && !bus.dreq_valid && !bus.ireq_valid) begin
            check("m_one_ready", bus.ireq_ready ^ bus.dreq_ready, 1);
        end else begin
            check("m_ireq_ready", bus.ireq_ready, exp_ri);
            check("m_dreq_ready", bus.dreq_ready, exp_rd);
        end
        check("m_busy", bus.busy, exp_busy);
        check("m_iresp_valid", bus.iresp_valid, exp_vi);
        check("m_dresp_valid", bus.dresp_valid, exp_vd);
        check("m_err", bus.err, m_err);
        if (m_known_i) check("m_iresp_data", bus.iresp_data, m_last_i);
        if (m_known_d) check("m_dresp_data", bus.dresp_data, m_last_d);
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a request, hold it until the model sees it accepted, then drop it.
    task automatic issue(input bit is_d, input logic [35:0] a, input bit we, input logic [127:0] wd);
        bit got;
        got = 0;
        if (is_d) begin
            bus.dreq_valid = 1; bus.dreq_addr = a; bus.dreq_we = we; bus.dreq_wdata = wd;
        end else begin
            bus.ireq_valid = 1; bus.ireq_addr = a;
        end
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            #1;
            got = is_d ? m_acc_d : m_acc_i;
        end
        check("accept_within_budget", got, 1);
        next_cycle();
        if (is_d) bus.dreq_valid = 0; else bus.ireq_valid = 0;
    endtask

    // Called right after issue(); lands on the response cycle (accept + LAT + 1).
    task automatic expect_resp(input bit is_d, input string name, input logic [127:0] exp);
        repeat (LAT + 1) @(negedge clk);
        check({name, "_valid"}, is_d ? bus.dresp_valid : bus.iresp_valid, 1);
        check({name, "_data"}, is_d ? bus.dresp_data : bus.iresp_data, exp);
    endtask

    // Valids already set by the caller; accepts expected at k=0,6,12 on the
    // ports given by port_d[0..2], responses at k=5,11,17.
    task automatic hold_pattern(input string tag, input logic [2:0] port_d);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check($sformatf("%s_busy_k%0d", tag, k), bus.busy, (k % 6) != 0);
            if (k % 6 == 0) begin
                check($sformatf("%s_dready_k%0d", tag, k), bus.dreq_ready, port_d[k/6]);
                check($sformatf("%s_iready_k%0d", tag, k), bus.ireq_ready, !port_d[k/6]);
            end
            if (k % 6 == 5) begin
                check($sformatf("%s_dresp_k%0d", tag, k), bus.dresp_valid, port_d[k/6]);
                check($sformatf("%s_iresp_k%0d", tag, k), bus.iresp_valid, !port_d[k/6]);
            end
            next_cycle();
            if (k == 12) begin
                bus.ireq_valid = 0;
                bus.dreq_valid = 0;
            end
        end
    endtask

    function automatic logic [35:0] rand_addr();
        logic [9:0]  idx;
        logic [21:0] hi;
        case ($urandom_range(0, 7))
            0: idx = 10'h000;  1: idx = 10'h001;  2: idx = 10'h002;  3: idx = 10'h004;
            4: idx = 10'h008;  5: idx = 10'h020;  6: idx = 10'h3FF;  default: idx = 10'h155;
        endcase
        hi = ($urandom_range(0, 15) == 0) ? 22'($urandom()) : 22'd0;
        return {hi, idx, 4'($urandom())};
    endfunction

    localparam logic [127:0] LINE_40 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] LINE_A  = 128'hAAAA0001AAAA0002AAAA0003AAAA0004;
    localparam logic [127:0] LINE_B  = 128'hBBBB0001BBBB0002BBBB0003BBBB0004;
    localparam logic [127:0] LINE_0  = 128'h0F0F0F0F12345678DEADBEEF00C0FFEE;
    localparam logic [127:0] LINE_L1 = 128'hCAFEF00D0000000111111111CAFEBABE;

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bus.ireq_valid = 0; bus.ireq_addr = '0;
        bus.dreq_valid = 0; bus.dreq_addr = '0; bus.dreq_we = 0; bus.dreq_wdata = '0;
        bus1.ireq_valid = 0; bus1.ireq_addr = '0;
        bus1.dreq_valid = 0; bus1.dreq_addr = '0; bus1.dreq_we = 0; bus1.dreq_wdata = '0;

        // Both ports valid from reset: data, instruction, data.
        bus.dreq_valid = 1; bus.dreq_addr = 36'h200; bus.dreq_we = 1; bus.dreq_wdata = LINE_B;
        bus.ireq_valid = 1; bus.ireq_addr = 36'h300;
        repeat (2) begin
            @(negedge clk);
            check("rst_dready", bus.dreq_ready, 0);
            check("rst_iready", bus.ireq_ready, 0);
            check("rst_ddata", bus.dresp_data, 0);
        end
        next_cycle();
        rst_n = 1;
        hold_pattern("arb", 3'b101);

        // Data write of 0x40, then instruction read of the same line.
        issue(1, 36'h000000040, 1, LINE_40);
        expect_resp(1, "wr40", LINE_40);
        next_cycle();
        issue(0, 36'h000000040, 0, '0);
        expect_resp(0, "rd40", LINE_40);
        next_cycle();

        // Three instruction reads held valid.
        bus.ireq_valid = 1; bus.ireq_addr = 36'h000000040;
        hold_pattern("irds", 3'b000);

        // Reset during WAIT of a write to 0x80.
        issue(1, 36'h000000080, 1, LINE_A);
        expect_resp(1, "wr80", LINE_A);
        next_cycle();
        issue(1, 36'h000000080, 1, LINE_B);
        rst_n = 0;
        @(negedge clk);
        check("midrst_dvalid", bus.dresp_valid, 0);
        check("midrst_ddata", bus.dresp_data, 0);
        check("midrst_idata", bus.iresp_data, 0);
        check("midrst_busy", bus.busy, 0);
        next_cycle();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("midrst_noresp_k%0d", k), bus.dresp_valid, 0);
        end
        next_cycle();
        issue(0, 36'h000000080, 0, '0);
        expect_resp(0, "rd80_after_rst", LINE_A);
        next_cycle();

        // Upper address bits: flagged with the range check, aliased without.
        issue(1, 36'h000000000, 1, LINE_0);
        expect_resp(1, "wr0", LINE_0);
        next_cycle();
        issue(0, 36'h000004000, 0, '0);
`ifdef FILL_RANGE_CHECK_EN
        expect_resp(0, "rd4000", 128'h0);
        check("rd4000_err", bus.err, 1);
`else
        expect_resp(0, "rd4000", LINE_0);
        check("rd4000_err", bus.err, 0);
`endif
        next_cycle();
        issue(0, 36'h000000040, 0, '0);
        expect_resp(0, "rd40_after_range", LINE_40);
`ifdef FILL_RANGE_CHECK_EN
        check("err_sticky", bus.err, 1);
`else
        check("err_tied", bus.err, 0);
`endif
        next_cycle();

        // Randomized traffic with occasional resets, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (m_acc_i) bus.ireq_valid = 0;
            if (m_acc_d) bus.dreq_valid = 0;
            if (c % 700 == 350) rst_n = 0;
            if (c % 700 == 352) rst_n = 1;
            if (!bus.ireq_valid && $urandom_range(0, 2) == 0) begin
                bus.ireq_valid = 1;
                bus.ireq_addr  = rand_addr();
            end
            if (!bus.dreq_valid && $urandom_range(0, 2) == 0) begin
                bus.dreq_valid = 1;
                bus.dreq_addr  = rand_addr();
                bus.dreq_we    = 1'($urandom_range(0, 1));
                bus.dreq_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        bus.ireq_valid = 0;
        bus.dreq_valid = 0;
        repeat (LAT + 3) next_cycle();

        // LATENCY=1 instance: write then immediate read of the same line.
        bus1.dreq_valid = 1; bus1.dreq_addr = 36'h30; bus1.dreq_we = 1; bus1.dreq_wdata = LINE_L1;
        @(negedge clk);
        check("l1_wr_ready", bus1.dreq_ready, 1);
        next_cycle();
        bus1.dreq_we = 0;
        @(negedge clk);
        check("l1_wait_busy", bus1.busy, 1);
        check("l1_wait_noresp", bus1.dresp_valid, 0);
        @(negedge clk);
        check("l1_wr_resp", bus1.dresp_valid, 1);
        check("l1_wr_echo", bus1.dresp_data, LINE_L1);
        @(negedge clk);
        check("l1_rd_ready", bus1.dreq_ready, 1);
        next_cycle();
        bus1.dreq_valid = 0;
        @(negedge clk);
        check("l1_rd_wait", bus1.dresp_valid, 0);
        @(negedge clk);
        check("l1_rd_resp", bus1.dresp_valid, 1);
        check("l1_rd_data", bus1.dresp_data, LINE_L1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
